dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_wbuf.sv | 90 +++++++++
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: word width, write-buffer entry
// layout and the drain FSM state encoding.
package dmem_pkg;

  localparam int WORD_W = 32;
  // Entry index is wide enough for any word address; the top zero-extends its
  // truncated RAM index so aliased byte addresses compare equal in the buffer.
  localparam int IDX_W  = 30;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [WORD_W-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    DRAIN_EMPTY   = 2'd0,
    DRAIN_PENDING = 2'd1,
    DRAIN_FULL    = 2'd2
  } drain_state_t;

  // Zero-extend a RAM word index into the buffer's index field.
  function automatic logic [IDX_W-1:0] entry_index(input logic [IDX_W-1:0] ram_idx);
    return ram_idx;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Posted write buffer: circular FIFO storage, head/tail pointers, a separate
// occupancy counter and a youngest-match lookup for read bypass.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wbuf_entry_t            push_entry,
  input  logic                   pop,
  output wbuf_entry_t            head_entry,
  input  logic [IDX_W-1:0]       lookup_index,
  output logic                   hit,
  output logic [WORD_W-1:0]      hit_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t       entries_q [DEPTH];
  logic [PTR_W-1:0]  head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0]  tail_ptr_q, tail_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Per-age view of the FIFO: age 0 is the head (oldest), age DEPTH-1 youngest.
  logic [DEPTH-1:0]  match_by_age;
  logic [WORD_W-1:0] data_by_age [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] slot;
      assign slot              = head_ptr_q + PTR_W'(gi);
      assign match_by_age[gi]  = (CNT_W'(gi) < count_q) &&
                                 (entries_q[slot].index == lookup_index);
      assign data_by_age[gi]   = entries_q[slot].data;
    end
  endgenerate

  // Youngest matching entry wins: later ages override earlier ones.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_by_age[k]) begin
        hit      = 1'b1;
        hit_data = data_by_age[k];
      end
    end
  end

  // Pointer and occupancy update; a simultaneous push and pop keeps occupancy.
  always_comb begin
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    if (push) tail_ptr_d = tail_ptr_q + PTR_W'(1);
    if (pop)  head_ptr_d = head_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all pending entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: validity comes from the occupancy counter.
  always_ff @(posedge clk) begin
    if (push) entries_q[tail_ptr_q] <= push_entry;
  end

  assign head_entry = entries_q[head_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed single-port RAM answering the core's
// data port every cycle with one-cycle read latency.
// Build option: define DMEM_WBUF_EN to place a posted write buffer (with read
// bypass and idle-cycle draining) in front of the RAM; otherwise writes go
// straight to RAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_ren,
  input  logic                        mem_wen,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_dout,
  output logic [31:0]                 mem_din,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
  output logic                        wbuf_empty,
  output logic                        align_err
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic [WORD_W-1:0] ram_mem [2**ADDR_W];

  logic              wr_cycle, rd_cycle, idle_cycle;
  logic [ADDR_W-1:0] word_idx;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata_q;
  logic              align_err_q, align_err_d;

  // Address bits above the RAM index alias onto the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];

  // Cycle classification: a write takes priority over a simultaneous read.
  always_comb begin
    wr_cycle   = mem_wen;
    rd_cycle   = mem_ren & ~mem_wen;
    idle_cycle = ~mem_ren & ~mem_wen;
    word_idx   = mem_addr[ADDR_W+1:2];
  end

`ifdef DMEM_WBUF_EN
  drain_state_t      state_q, state_d;
  logic              drain;
  wbuf_entry_t       push_entry;
  wbuf_entry_t       head_entry;
  logic              buf_hit;
  logic [WORD_W-1:0] buf_hit_data;
  logic [CNT_W-1:0]  buf_count;
  logic              byp_hit_q, byp_hit_d;
  logic [WORD_W-1:0] byp_data_q, byp_data_d;
  logic              unused_head_index;

  assign push_entry.index = entry_index(IDX_W'(word_idx));
  assign push_entry.data  = mem_dout;

  dmem_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (wr_cycle),
    .push_entry   (push_entry),
    .pop          (drain),
    .head_entry   (head_entry),
    .lookup_index (push_entry.index),
    .hit          (buf_hit),
    .hit_data     (buf_hit_data),
    .count        (buf_count)
  );

  // Drain FSM: drain the head on idle cycles, and force a drain when a write
  // arrives with the buffer full so no write is lost.
  always_comb begin
    state_d = state_q;
    drain   = 1'b0;
    case (state_q)
      DRAIN_EMPTY: begin
        if (wr_cycle) state_d = DRAIN_PENDING;
      end
      DRAIN_PENDING: begin
        if (wr_cycle) begin
          if (buf_count == CNT_W'(WBUF_DEPTH - 1)) state_d = DRAIN_FULL;
        end else if (idle_cycle) begin
          drain = 1'b1;
          if (buf_count == CNT_W'(1)) state_d = DRAIN_EMPTY;
        end
      end
      DRAIN_FULL: begin
        if (wr_cycle) begin
          drain = 1'b1;
        end else if (idle_cycle) begin
          drain   = 1'b1;
          state_d = DRAIN_PENDING;
        end
      end
      default: state_d = DRAIN_EMPTY;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DRAIN_EMPTY;
    else        state_q <= state_d;
  end

  // RAM write port is fed from the buffer head; held off while in reset.
  always_comb begin
    ram_we    = drain & rst_n;
    ram_waddr = head_entry.index[ADDR_W-1:0];
    ram_wdata = head_entry.data;
  end
  assign unused_head_index = ^head_entry.index;

  // Capture the bypass decision alongside the RAM read of a READ cycle.
  always_comb begin
    byp_hit_d  = byp_hit_q;
    byp_data_d = byp_data_q;
    if (rd_cycle) begin
      byp_hit_d  = buf_hit;
      byp_data_d = buf_hit_data;
    end
  end

  // Bypass registers; cleared so mem_din reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign mem_din    = byp_hit_q ? byp_data_q : ram_rdata_q;
  assign wbuf_count = buf_count;
  assign wbuf_empty = (buf_count == '0);
`else
  // Without the buffer every write lands in RAM in its own cycle.
  always_comb begin
    ram_we    = wr_cycle & rst_n;
    ram_waddr = word_idx;
    ram_wdata = mem_dout;
  end

  assign mem_din    = ram_rdata_q;
  assign wbuf_count = '0;
  assign wbuf_empty = 1'b1;
`endif

  // RAM write port.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
  end

  // Registered RAM read, updated only by READ cycles so mem_din holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ram_rdata_q <= '0;
    else if (rd_cycle) ram_rdata_q <= ram_mem[word_idx];
  end

  // Sticky misalignment flag for any read or write access.
  always_comb begin
    align_err_d = align_err_q;
    if ((mem_ren | mem_wen) && (mem_addr[1:0] != 2'b00)) align_err_d = 1'b1;
  end

  // Misalignment flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_err_q <= 1'b0;
    else        align_err_q <= align_err_d;
  end

  assign align_err = align_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder. Buffer-dependent
// expectations follow the DMEM_WBUF_EN build option.
module tb_dmem_responder;

`ifdef DMEM_WBUF_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic [2:0]  wbuf_count;
  logic        wbuf_empty;
  logic        align_err;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.ADDR_W(10), .WBUF_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .wbuf_count (wbuf_count),
    .wbuf_empty (wbuf_empty),
    .align_err  (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then settle 1ns past the closing edge.
  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data);
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h expected %h", mem_din, 32'h0); end
    checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", wbuf_count); end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", wbuf_empty); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align: got %b expected 0", align_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("reset released");
  endtask

  task automatic test_write_idle_read;
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    $display("write @10 = deadbeef count=%0d din=%h", wbuf_count, mem_din);
    checks++; if (wbuf_count !== 3'(WB)) begin errors++; $display("FAIL wir_count1: got %0d expected %0d", wbuf_count, WB); end
    checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL wir_din_hold: got %h expected %h", mem_din, 32'h0); end
    idle(1);
    $display("idle count=%0d", wbuf_count);
    checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL wir_count0: got %0d expected 0", wbuf_count); end
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    $display("read @10 din=%h", mem_din);
    checks++; if (mem_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wir_read: got %h expected %h", mem_din, 32'hDEADBEEF); end
  endtask

  task automatic test_bypass;
    drive(1'b0, 1'b1, 32'h20, 32'h1);
    drive(1'b0, 1'b1, 32'h20, 32'h2);
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    $display("read @20 after two writes din=%h count=%0d", mem_din, wbuf_count);
    checks++; if (mem_din !== 32'h2) begin errors++; $display("FAIL bypass_read: got %h expected %h", mem_din, 32'h2); end
    checks++; if (wbuf_count !== 3'(2 * WB)) begin errors++; $display("FAIL bypass_count: got %0d expected %0d", wbuf_count, 2 * WB); end
    idle(2);
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL bypass_empty: got %b expected 1", wbuf_empty); end
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    $display("read @20 after drain din=%h", mem_din);
    checks++; if (mem_din !== 32'h2) begin errors++; $display("FAIL bypass_ram: got %h expected %h", mem_din, 32'h2); end
  endtask

  task automatic test_back_to_back;
    int exp_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 32'hA0 + 32'(i));
      exp_cnt = ((i + 1) > 4 ? 4 : (i + 1)) * WB;
      $display("write @%h = %h count=%0d", i * 4, 32'hA0 + 32'(i), wbuf_count);
      checks++; if (wbuf_count !== 3'(exp_cnt)) begin errors++; $display("FAIL b2b_count%0d: got %0d expected %0d", i, wbuf_count, exp_cnt); end
    end
    // Oldest entry was force-drained; youngest @0x10 still bypasses.
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    $display("read @0 din=%h", mem_din);
    checks++; if (mem_din !== 32'hA0) begin errors++; $display("FAIL b2b_drained: got %h expected %h", mem_din, 32'hA0); end
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    $display("read @10 din=%h", mem_din);
    checks++; if (mem_din !== 32'hA4) begin errors++; $display("FAIL b2b_young: got %h expected %h", mem_din, 32'hA4); end
    idle(4);
    checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL b2b_drain_count: got %0d expected 0", wbuf_count); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4), 32'h0);
      $display("read @%h din=%h", i * 4, mem_din);
      checks++; if (mem_din !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL b2b_read%0d: got %h expected %h", i, mem_din, 32'hA0 + 32'(i)); end
    end
  endtask

  task automatic test_rw_both;
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    drive(1'b1, 1'b1, 32'h30, 32'h55);
    $display("ren+wen @30 = 55 din=%h count=%0d", mem_din, wbuf_count);
    checks++; if (mem_din !== 32'h2) begin errors++; $display("FAIL rw_din_hold: got %h expected %h", mem_din, 32'h2); end
    checks++; if (wbuf_count !== 3'(WB)) begin errors++; $display("FAIL rw_count: got %0d expected %0d", wbuf_count, WB); end
    idle(1);
    drive(1'b1, 1'b0, 32'h30, 32'h0);
    $display("read @30 din=%h", mem_din);
    checks++; if (mem_din !== 32'h55) begin errors++; $display("FAIL rw_read: got %h expected %h", mem_din, 32'h55); end
  endtask

  task automatic test_align;
    drive(1'b0, 1'b1, 32'h40, 32'h77);
    idle(1);
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_pre: got %b expected 0", align_err); end
    drive(1'b1, 1'b0, 32'h42, 32'h0);
    $display("read @42 din=%h align_err=%b", mem_din, align_err);
    checks++; if (mem_din !== 32'h77) begin errors++; $display("FAIL align_read: got %h expected %h", mem_din, 32'h77); end
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_set: got %b expected 1", align_err); end
    idle(2);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sticky: got %b expected 1", align_err); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp;
    drive(1'b0, 1'b1, 32'h0, 32'h111);
    drive(1'b0, 1'b1, 32'h4, 32'h222);
    drive(1'b0, 1'b1, 32'h8, 32'h333);
    checks++; if (wbuf_count !== 3'(3 * WB)) begin errors++; $display("FAIL rst_pre_count: got %0d expected %0d", wbuf_count, 3 * WB); end
    mem_ren = 1'b0; mem_wen = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset din=%h count=%0d empty=%b align=%b", mem_din, wbuf_count, wbuf_empty, align_err);
    checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL rst_mid_din: got %h expected %h", mem_din, 32'h0); end
    checks++; if (wbuf_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", wbuf_count); end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b expected 1", wbuf_empty); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL rst_mid_align: got %b expected 0", align_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'(i * 4), 32'h0);
      exp = (WB != 0) ? 32'hA0 + 32'(i) : 32'h111 * 32'(i + 1);
      $display("post-reset read @%h din=%h", i * 4, mem_din);
      checks++; if (mem_din !== exp) begin errors++; $display("FAIL rst_ram%0d: got %h expected %h", i, mem_din, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_idle_read();
    test_bypass();
    test_back_to_back();
    test_rw_both();
    test_align();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
